rob_commit_unit: RTL

- 8-entry reorder buffer for the Tomasulo core. Issue allocates entries in program order at the tail. The CDB marks entries complete out of order.
- The block retires one entry per cycle from the head. Retirement writes the register bank or memory, or squashes the machine on a taken branch.
- It is the in-order retire end of the fetch/issue path. It consumes the 16-bit instruction format (func, rs1, rs2, rd) already decoded by issue.

---
 rtl/rob_commit_unit.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/rob_commit_unit.sv
// Reorder buffer: in-order allocate at the tail, out-of-order CDB completion, one retire per cycle.
// Optional ROB_PERF_EN macro adds saturating commit_count/flush_count outputs.
module rob_commit_unit #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned IDX_W  = 3,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              alloc_valid,
    input  logic [3:0]        alloc_func,
    input  logic [3:0]        alloc_rd,
    output logic              alloc_ready,
    output logic [IDX_W-1:0]  alloc_idx,
    input  logic              cdb_valid,
    input  logic [IDX_W-1:0]  cdb_rob_ind,
    input  logic [DATA_W-1:0] cdb_value,
    input  logic [7:0]        cdb_addr,
    input  logic              cdb_taken,
    output logic              reg_we,
    output logic [3:0]        reg_waddr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic [IDX_W-1:0]  reg_wrob,
    output logic              mem_we,
    output logic [7:0]        mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              flush,
    output logic [3:0]        flush_target,
`ifdef ROB_PERF_EN
    output logic [15:0]       commit_count,
    output logic [7:0]        flush_count,
`endif
    output logic              rob_empty
);

    localparam logic [3:0] FUNC_ADD   = 4'b0000;
    localparam logic [3:0] FUNC_SUB   = 4'b0001;
    localparam logic [3:0] FUNC_MUL   = 4'b0010;
    localparam logic [3:0] FUNC_DIV   = 4'b0011;
    localparam logic [3:0] FUNC_LOAD  = 4'b0100;
    localparam logic [3:0] FUNC_STORE = 4'b0101;
    localparam logic [3:0] FUNC_BEQ   = 4'b0110;
    localparam logic [3:0] FUNC_BNEQ  = 4'b0111;

    localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [IDX_W:0]   CNT_ONE  = {{IDX_W{1'b0}}, 1'b1};
    localparam logic [IDX_W:0]   FULL_CNT = (IDX_W+1)'(DEPTH);

    // Entry storage
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [DEPTH-1:0]  done_q, done_d;
    logic [DEPTH-1:0]  taken_q, taken_d;
    logic [3:0]        func_q  [DEPTH];
    logic [3:0]        func_d  [DEPTH];
    logic [3:0]        rd_q    [DEPTH];
    logic [3:0]        rd_d    [DEPTH];
    logic [DATA_W-1:0] value_q [DEPTH];
    logic [DATA_W-1:0] value_d [DEPTH];
    logic [7:0]        addr_q  [DEPTH];
    logic [7:0]        addr_d  [DEPTH];

    logic [IDX_W-1:0]  head_q, head_d;
    logic [IDX_W-1:0]  tail_q, tail_d;
    logic [IDX_W:0]    count_q, count_d;

    // Registered retire outputs
    logic              reg_we_q, reg_we_d;
    logic [3:0]        reg_waddr_q, reg_waddr_d;
    logic [DATA_W-1:0] reg_wdata_q, reg_wdata_d;
    logic [IDX_W-1:0]  reg_wrob_q, reg_wrob_d;
    logic              mem_we_q, mem_we_d;
    logic [7:0]        mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              flush_q, flush_d;
    logic [3:0]        flush_target_q, flush_target_d;

    logic       head_valid, head_done, head_taken, head_is_br;
    logic [3:0] head_func;
    logic       commit, squash_now, full, do_alloc, cdb_hit;

    assign head_valid = valid_q[head_q];
    assign head_done  = done_q[head_q];
    assign head_taken = taken_q[head_q];
    assign head_func  = func_q[head_q];
    assign head_is_br = (head_func == FUNC_BEQ) || (head_func == FUNC_BNEQ);

    assign commit     = head_valid && head_done;
    assign squash_now = commit && head_is_br && head_taken;
    // Full uses the registered count: a same-cycle retire does not free a slot.
    assign full       = (count_q == FULL_CNT);
    assign do_alloc   = alloc_valid && alloc_ready;
    assign cdb_hit    = cdb_valid && valid_q[cdb_rob_ind] && !done_q[cdb_rob_ind];

    assign alloc_ready = !full && !squash_now;
    assign alloc_idx   = tail_q;
    assign rob_empty   = (count_q == '0);

    always_comb begin
        valid_d = valid_q;
        done_d  = done_q;
        taken_d = taken_q;
        func_d  = func_q;
        rd_d    = rd_q;
        value_d = value_q;
        addr_d  = addr_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        if (squash_now) begin
            // Taken branch wipes the buffer; any same-edge CDB write is dropped.
            valid_d = '0;
            done_d  = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (cdb_hit) begin
                done_d[cdb_rob_ind]  = 1'b1;
                value_d[cdb_rob_ind] = cdb_value;
                addr_d[cdb_rob_ind]  = cdb_addr;
                taken_d[cdb_rob_ind] = cdb_taken;
            end
            if (commit) begin
                valid_d[head_q] = 1'b0;
                done_d[head_q]  = 1'b0;
                head_d          = head_q + IDX_ONE;
            end
            if (do_alloc) begin
                valid_d[tail_q] = 1'b1;
                done_d[tail_q]  = 1'b0;
                func_d[tail_q]  = alloc_func;
                rd_d[tail_q]    = alloc_rd;
                tail_d          = tail_q + IDX_ONE;
            end
            case ({do_alloc, commit})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_comb begin
        reg_we_d       = 1'b0;
        reg_waddr_d    = reg_waddr_q;
        reg_wdata_d    = reg_wdata_q;
        reg_wrob_d     = reg_wrob_q;
        mem_we_d       = 1'b0;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        flush_d        = 1'b0;
        flush_target_d = flush_target_q;

        if (commit) begin
            case (head_func)
                FUNC_ADD, FUNC_SUB, FUNC_MUL, FUNC_DIV, FUNC_LOAD: begin
                    reg_we_d    = 1'b1;
                    reg_waddr_d = rd_q[head_q];
                    reg_wdata_d = value_q[head_q];
                    reg_wrob_d  = head_q;
                end
                FUNC_STORE: begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_q[head_q];
                    mem_wdata_d = value_q[head_q];
                end
                FUNC_BEQ, FUNC_BNEQ: begin
                    if (head_taken) begin
                        flush_d        = 1'b1;
                        flush_target_d = rd_q[head_q];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            done_q  <= '0;
            taken_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                func_q[i]  <= '0;
                rd_q[i]    <= '0;
                value_q[i] <= '0;
                addr_q[i]  <= '0;
            end
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            reg_we_q       <= 1'b0;
            reg_waddr_q    <= '0;
            reg_wdata_q    <= '0;
            reg_wrob_q     <= '0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            flush_q        <= 1'b0;
            flush_target_q <= '0;
        end else begin
            valid_q        <= valid_d;
            done_q         <= done_d;
            taken_q        <= taken_d;
            func_q         <= func_d;
            rd_q           <= rd_d;
            value_q        <= value_d;
            addr_q         <= addr_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            reg_we_q       <= reg_we_d;
            reg_waddr_q    <= reg_waddr_d;
            reg_wdata_q    <= reg_wdata_d;
            reg_wrob_q     <= reg_wrob_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            flush_q        <= flush_d;
            flush_target_q <= flush_target_d;
        end
    end

    assign reg_we       = reg_we_q;
    assign reg_waddr    = reg_waddr_q;
    assign reg_wdata    = reg_wdata_q;
    assign reg_wrob     = reg_wrob_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign flush        = flush_q;
    assign flush_target = flush_target_q;

`ifdef ROB_PERF_EN
    logic [15:0] commit_count_q, commit_count_d;
    logic [7:0]  flush_count_q, flush_count_d;

    always_comb begin
        commit_count_d = commit_count_q;
        flush_count_d  = flush_count_q;
        if (commit && (commit_count_q != 16'hffff)) begin
            commit_count_d = commit_count_q + 16'd1;
        end
        if (squash_now && (flush_count_q != 8'hff)) begin
            flush_count_d = flush_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            commit_count_q <= '0;
            flush_count_q  <= '0;
        end else begin
            commit_count_q <= commit_count_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign commit_count = commit_count_q;
    assign flush_count  = flush_count_q;
`endif

endmodule
